pipe_hazard_ctrl: RTL and testbench

Sequential hazard and pipeline-control unit for the 5-stage RV32I core (F, D, X, M, W). It sits beside the combinational decode controller. It tracks in-flight instructions in a per-stage scoreboard and generates stall, bubble, kill and forwarding-select signals. Parametrised in load latency, flush depth and register-address width, it replaces the fixed hazard_controls tie-off with real interlocks.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 34 +++
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_hazard_ctrl_reg_use_dec.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and decode payload for the pipeline hazard unit.
//   RV32I base opcodes, forwarding-select encodings, legal load-latency
//   range and the reg_use_t decode record.
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
  localparam logic [6:0] OPC_ARI_R  = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam int unsigned LOAD_LAT_MIN = 1;
  localparam int unsigned LOAD_LAT_MAX = 3;
  localparam int unsigned LOAD_CNT_W   = 2;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_load;
    logic illegal;
  } reg_use_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-slot inputs and pipeline-control outputs of the hazard unit.
//   master: pipeline side driving D-slot info, redirect and dmem stall
//   slave : hazard unit returning stall/bubble/kill/forward/illegal
interface pipe_hazard_ctrl_if;
  logic [31:0] d_inst;
  logic        d_valid;
  logic        x_redirect;
  logic        dmem_stall;
  logic        stall_f;
  logic        stall_d;
  logic        bubble_x;
  logic        kill_d;
  logic        kill_f;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        illegal_d;

  modport master (
    output d_inst, d_valid, x_redirect, dmem_stall,
    input  stall_f, stall_d, bubble_x, kill_d, kill_f,
           fwd_a_sel, fwd_b_sel, illegal_d
  );

  modport slave (
    input  d_inst, d_valid, x_redirect, dmem_stall,
    output stall_f, stall_d, bubble_x, kill_d, kill_f,
           fwd_a_sel, fwd_b_sel, illegal_d
  );
endinterface

// File: rtl/pipe_hazard_ctrl_reg_use_dec.sv
// Combinational opcode decoder: which register fields an instruction
// reads/writes, whether it is a load, and whether the opcode is outside
// the RV32I base set.
//   opcode    : instruction bits [6:0]
//   reg_use_c : decoded register-usage record
module pipe_hazard_ctrl_reg_use_dec
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output reg_use_t   reg_use_c
);

  always_comb begin
    reg_use_c = '0;
    unique case (opcode)
      OPC_ARI_R: begin
        reg_use_c.uses_rs1  = 1'b1;
        reg_use_c.uses_rs2  = 1'b1;
        reg_use_c.writes_rd = 1'b1;
      end
      OPC_ARI_I, OPC_JALR: begin
        reg_use_c.uses_rs1  = 1'b1;
        reg_use_c.writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        reg_use_c.uses_rs1  = 1'b1;
        reg_use_c.writes_rd = 1'b1;
        reg_use_c.is_load   = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        reg_use_c.uses_rs1 = 1'b1;
        reg_use_c.uses_rs2 = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        reg_use_c.writes_rd = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        reg_use_c = '0;
      end
      default: begin
        reg_use_c.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and control unit for the 5-stage RV32I core.
// Tracks X/M/W occupancy in a scoreboard and produces load-use stalls,
// redirect kills, dmem freeze and operand forwarding selects.
//   clk, reset : core clock, asynchronous active-high reset
//   hz (slave) : D-slot instruction/valid, x_redirect, dmem_stall in;
//                stall_f/stall_d/bubble_x/kill_d/kill_f, fwd_a/b_sel,
//                illegal_d out (combinational from inputs + scoreboard)
// LOAD_LAT must lie in LOAD_LAT_MIN..LOAD_LAT_MAX; FLUSH_SLOTS is 1 or 2.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              is_load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } slot_t;

  logic [31:0]           inst;
  logic                  unused_inst;
  reg_use_t              dec_c;
  slot_t                 d_slot;
  slot_t                 x_q, m_q, w_q, x_d, m_d, w_d;
  logic [LOAD_CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_AW-1:0]     load_rd_q, load_rd_d;
  logic                  out_en_q;
  logic                  load_hit;
  logic                  stall_f_c, stall_d_c, bubble_x_c, kill_d_c, kill_f_c;
  logic [1:0]            fwd_a_c, fwd_b_c;

  assign inst        = hz.d_inst;
  assign unused_inst = ^inst;

  pipe_hazard_ctrl_reg_use_dec u_dec (
    .opcode    (inst[6:0]),
    .reg_use_c (dec_c)
  );

  // Youngest non-load writer in M wins over W; x0 and unused fields never match.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input slot_t m, input slot_t w);
    if (rs == '0)                                          return FWD_RF;
    else if (m.valid && m.wen && !m.is_load && m.rd == rs) return FWD_M;
    else if (w.valid && w.wen && w.rd == rs)               return FWD_W;
    else                                                   return FWD_RF;
  endfunction

  // D-slot scoreboard entry; unused fields are zeroed so they cannot match.
  always_comb begin
    d_slot = '0;
    if (hz.d_valid && !dec_c.illegal) begin
      d_slot.valid   = 1'b1;
      d_slot.is_load = dec_c.is_load;
      d_slot.rd      = dec_c.writes_rd ? inst[7 +: REG_AW] : '0;
      d_slot.wen     = dec_c.writes_rd && (inst[7 +: REG_AW] != '0);
      d_slot.rs1     = dec_c.uses_rs1 ? inst[15 +: REG_AW] : '0;
      d_slot.rs2     = dec_c.uses_rs2 ? inst[20 +: REG_AW] : '0;
    end
  end

  // Control outputs; out_en_q keeps everything low for the first cycle after reset.
  always_comb begin
    stall_f_c  = 1'b0;
    stall_d_c  = 1'b0;
    bubble_x_c = 1'b0;
    kill_d_c   = 1'b0;
    kill_f_c   = 1'b0;
    fwd_a_c    = FWD_RF;
    fwd_b_c    = FWD_RF;
    load_hit   = (cnt_q != '0) && (load_rd_q != '0) &&
                 ((d_slot.rs1 == load_rd_q) || (d_slot.rs2 == load_rd_q));
    if (out_en_q) begin
      fwd_a_c = fwd_sel(x_q.rs1, m_q, w_q);
      fwd_b_c = fwd_sel(x_q.rs2, m_q, w_q);
      if (hz.dmem_stall) begin
        stall_f_c = 1'b1;
        stall_d_c = 1'b1;
      end else if (hz.x_redirect) begin
        kill_d_c = 1'b1;
        kill_f_c = (FLUSH_SLOTS == 2);
      end else if (load_hit) begin
        stall_f_c  = 1'b1;
        stall_d_c  = 1'b1;
        bubble_x_c = 1'b1;
      end
    end
  end

  // Scoreboard shift and load counter; everything holds while frozen.
  always_comb begin
    x_d       = x_q;
    m_d       = m_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    load_rd_d = load_rd_q;
    if (out_en_q && !hz.dmem_stall) begin
      x_d = (bubble_x_c || kill_d_c) ? '0 : d_slot;
      m_d = x_q;
      w_d = m_q;
      if (x_d.valid && x_d.is_load) begin
        cnt_d     = LOAD_CNT_W'(LOAD_LAT);
        load_rd_d = x_d.rd;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - LOAD_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_en_q  <= 1'b0;
      x_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      cnt_q     <= '0;
      load_rd_q <= '0;
    end else begin
      out_en_q  <= 1'b1;
      x_q       <= x_d;
      m_q       <= m_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      load_rd_q <= load_rd_d;
    end
  end

  assign hz.stall_f   = stall_f_c;
  assign hz.stall_d   = stall_d_c;
  assign hz.bubble_x  = bubble_x_c;
  assign hz.kill_d    = kill_d_c;
  assign hz.kill_f    = kill_f_c;
  assign hz.fwd_a_sel = fwd_a_c;
  assign hz.fwd_b_sel = fwd_b_c;
  assign hz.illegal_d = out_en_q && hz.d_valid && dec_c.illegal;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dut_a (LOAD_LAT=1, FLUSH_SLOTS=2)
// and dut_b (LOAD_LAT=3, FLUSH_SLOTS=1) share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_inst;
  logic        d_valid;
  logic        x_redirect;
  logic        dmem_stall;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if if_a ();
  pipe_hazard_ctrl_if if_b ();

  assign if_a.d_inst = d_inst;     assign if_b.d_inst = d_inst;
  assign if_a.d_valid = d_valid;   assign if_b.d_valid = d_valid;
  assign if_a.x_redirect = x_redirect; assign if_b.x_redirect = x_redirect;
  assign if_a.dmem_stall = dmem_stall; assign if_b.dmem_stall = dmem_stall;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_SLOTS(2)) dut_a (
    .clk(clk), .reset(reset), .hz(if_a)
  );
  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_SLOTS(1)) dut_b (
    .clk(clk), .reset(reset), .hz(if_b)
  );

  // Output vector layout: {stall_f, stall_d, bubble_x, kill_d, kill_f}_{fwd_a}_{fwd_b}_{illegal_d}
  logic [9:0] out_a, out_b;
  assign out_a = {if_a.stall_f, if_a.stall_d, if_a.bubble_x, if_a.kill_d, if_a.kill_f,
                  if_a.fwd_a_sel, if_a.fwd_b_sel, if_a.illegal_d};
  assign out_b = {if_b.stall_f, if_b.stall_d, if_b.bubble_x, if_b.kill_d, if_b.kill_f,
                  if_b.fwd_a_sel, if_b.fwd_b_sel, if_b.illegal_d};

  localparam logic [9:0] V0     = 10'b00000_00_00_0;
  localparam logic [9:0] VSTALL = 10'b11100_00_00_0;
  localparam logic [9:0] VILL   = 10'b00000_00_00_1;

  function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    d_valid    = 1'b0;
    d_inst     = 32'h0;
    x_redirect = 1'b0;
    dmem_stall = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; d_valid = 1'b1; d_inst = 32'h0000_007F;
    dmem_stall = 1'b1; x_redirect = 1'b1;
    @(negedge clk);
    tests++;
    if (out_a !== V0 || out_b !== V0) begin
      $display("FAIL reset_held a=%b b=%b want %b", out_a, out_b, V0); fails++;
    end
    next_cycle();
    reset = 1'b0; dmem_stall = 1'b0;
    @(negedge clk);
    tests++;
    if (out_a !== V0 || out_b !== V0) begin
      $display("FAIL reset_first_cycle a=%b b=%b want %b", out_a, out_b, V0); fails++;
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (out_a !== 10'b00011_00_00_1 || out_b !== 10'b00010_00_00_1) begin
      $display("FAIL reset_second_cycle a=%b want %b b=%b want %b",
               out_a, 10'b00011_00_00_1, out_b, 10'b00010_00_00_1); fails++;
    end
    next_cycle();
  endtask

  task automatic test_forwarding();
    logic [31:0] prog [8];
    logic [9:0]  expv [8];
    flush();
    prog = '{f_add(5'd1, 5'd2, 5'd3), f_add(5'd4, 5'd1, 5'd5), f_add(5'd6, 5'd1, 5'd0),
             f_add(5'd7, 5'd2, 5'd2), f_add(5'd7, 5'd3, 5'd3), f_add(5'd8, 5'd7, 5'd7),
             32'h0, 32'h0};
    expv = '{V0, V0, 10'b00000_01_00_0, 10'b00000_10_00_0, V0, V0,
             10'b00000_01_01_0, V0};
    for (int k = 0; k < 8; k++) begin
      d_inst = prog[k]; d_valid = (k < 6);
      @(negedge clk);
      tests++;
      if (out_a !== expv[k] || out_b !== expv[k]) begin
        $display("FAIL fwd[%0d] a=%b b=%b want %b", k, out_a, out_b, expv[k]); fails++;
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    logic [9:0] ea [6];
    logic [9:0] eb [6];
    flush();
    ea = '{V0, VSTALL, V0, 10'b00000_10_10_0, V0, V0};
    eb = '{V0, VSTALL, VSTALL, VSTALL, V0, V0};
    for (int k = 0; k < 6; k++) begin
      d_inst = (k == 0) ? f_lw(5'd5, 5'd1) : f_add(5'd6, 5'd5, 5'd5); d_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (out_a !== ea[k] || out_b !== eb[k]) begin
        $display("FAIL load_use[%0d] a=%b want %b b=%b want %b", k, out_a, ea[k], out_b, eb[k]);
        fails++;
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] prog [4];
    logic [9:0]  ea [4];
    logic [9:0]  eb [4];
    flush();
    prog = '{f_lw(5'd5, 5'd1), f_add(5'd5, 5'd5, 5'd5), f_add(5'd6, 5'd5, 5'd5),
             f_add(5'd6, 5'd5, 5'd5)};
    ea = '{V0, 10'b00011_00_00_0, V0, 10'b00000_10_10_0};
    eb = '{V0, 10'b00010_00_00_0, VSTALL, VSTALL};
    for (int k = 0; k < 4; k++) begin
      d_inst = prog[k]; d_valid = 1'b1; x_redirect = (k == 1);
      @(negedge clk);
      tests++;
      if (out_a !== ea[k] || out_b !== eb[k]) begin
        $display("FAIL redirect[%0d] a=%b want %b b=%b want %b", k, out_a, ea[k], out_b, eb[k]);
        fails++;
      end
      next_cycle();
    end
    x_redirect = 1'b0;
  endtask

  task automatic test_dmem_stall();
    logic [9:0] ea [10];
    logic [9:0] eb [10];
    flush();
    ea = '{V0, V0, 10'b11000_01_00_0, 10'b11000_01_00_0, 10'b11000_01_00_0,
           10'b11000_01_00_0, 10'b11100_01_00_0, V0, 10'b00000_10_10_0, V0};
    eb = '{V0, V0, 10'b11000_01_00_0, 10'b11000_01_00_0, 10'b11000_01_00_0,
           10'b11000_01_00_0, 10'b11100_01_00_0, VSTALL, VSTALL, V0};
    for (int k = 0; k < 10; k++) begin
      d_inst = (k == 0) ? f_add(5'd1, 5'd2, 5'd3) :
               (k == 1) ? f_lw(5'd5, 5'd1) : f_add(5'd6, 5'd5, 5'd5);
      d_valid = 1'b1; dmem_stall = (k >= 2 && k <= 5);
      @(negedge clk);
      tests++;
      if (out_a !== ea[k] || out_b !== eb[k]) begin
        $display("FAIL dmem_stall[%0d] a=%b want %b b=%b want %b", k, out_a, ea[k], out_b, eb[k]);
        fails++;
      end
      next_cycle();
    end
    dmem_stall = 1'b0;
  endtask

  task automatic test_x0_illegal();
    logic [31:0] prog [6];
    logic [9:0]  expv [6];
    flush();
    prog = '{f_lw(5'd0, 5'd1), f_add(5'd1, 5'd0, 5'd0), 32'h0000_007F, f_lw(5'd5, 5'd2),
             {7'h00, 5'd5, 5'd5, 3'b000, 5'd6, 7'h7F}, f_add(5'd6, 5'd5, 5'd5)};
    expv = '{V0, V0, VILL, V0, VILL, V0};
    for (int k = 0; k < 6; k++) begin
      d_inst = prog[k]; d_valid = (k < 5);
      @(negedge clk);
      tests++;
      if (out_a !== expv[k] || out_b !== expv[k]) begin
        $display("FAIL x0_illegal[%0d] a=%b b=%b want %b", k, out_a, out_b, expv[k]); fails++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_stall();
    flush();
    d_inst = f_lw(5'd5, 5'd1); d_valid = 1'b1;
    next_cycle();
    d_inst = f_add(5'd6, 5'd5, 5'd5);
    next_cycle();
    @(negedge clk);
    tests++;
    if (out_b !== VSTALL) begin
      $display("FAIL mid_stall_pre b=%b want %b", out_b, VSTALL); fails++;
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (out_a !== V0 || out_b !== V0) begin
      $display("FAIL mid_stall_async a=%b b=%b want %b", out_a, out_b, V0); fails++;
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (out_a !== V0 || out_b !== V0) begin
      $display("FAIL mid_stall_release a=%b b=%b want %b", out_a, out_b, V0); fails++;
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (out_a !== V0 || out_b !== V0) begin
      $display("FAIL mid_stall_after a=%b b=%b want %b", out_a, out_b, V0); fails++;
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_dmem_stall();
    test_x0_illegal();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
